sample_loader: RTL and testbench
================================

Name: sample_loader

Overview:
- Writer-side counterpart to the correlation unit. Operator keys 4-bit samples on slide switches and commits each one with a push-button.
- Fills sample buffer A, then sample buffer B. Both buffers sit behind a read port the correlator indexes directly.
- Signals completion with a one-cycle start pulse and a level done flag, so the correlator runs on user-loaded data instead of fixed ROM contents.

Parameters:
- DW, 4, sample width in bits.
- DEPTH, 8, entries per buffer.
- AW, $clog2(DEPTH), address width (derived; not overridden).
- DEBOUNCE_CYC, 1000000, consecutive stable clk cycles required to accept a button level change.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- data_sw  in  DW  sample value switches (asynchronous, slow).
- load_btn  in  1  commit button, active-high, bouncy.
- clear_btn  in  1  restart-load button, active-high, bouncy.
- rd_addr  in  AW  correlator read index.
- rd_a  out  DW  buffer A entry at rd_addr (combinational).
- rd_b  out  DW  buffer B entry at rd_addr (combinational).
- wr_idx  out  AW  next entry to be written (for display).
- phase  out  2  0=LOAD_A, 1=LOAD_B, 2=DONE.
- start  out  1  one-cycle pulse on entry to DONE.
- load_done  out  1  high while in DONE.

Behaviour:
- Reset (async, active-low):
  - state=LOAD_A, wr_idx=0, start=0, load_done=0.
  - All buffer entries = 0; debouncers cleared to released (0).
- Button conditioning:
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles; any mismatch-free cycle restarts the count.
  - commit = one-cycle pulse on debounced load_btn rising edge. clr = one-cycle pulse on debounced clear_btn rising edge.
  - Latency from clean button edge to commit: 2 + DEBOUNCE_CYC + 1 cycles.
- data_sw is sampled on the commit cycle through a 2-flop synchronizer. The switches are assumed stable for >> 2 cycles before the press.
- State machine:
  - LOAD_A, commit: mem_a[wr_idx] <= data_sw; if wr_idx==DEPTH-1 then wr_idx<=0, go LOAD_B; else wr_idx++.
  - LOAD_B, commit: mem_b[wr_idx] <= data_sw; if wr_idx==DEPTH-1 then wr_idx<=0, go DONE and assert start for exactly that transition cycle +1 (registered); else wr_idx++.
  - DONE: commit ignored, no writes, start stays 0 after its pulse, load_done=1.
  - Any state, clr: go LOAD_A, wr_idx=0, load_done=0. Buffer contents are retained and overwritten only as new commits arrive.
- Simultaneous events:
  - clr and commit in the same cycle: clr wins and no write occurs.
  - Reset mid-load: everything returns to reset values, including buffer contents.
- Read port:
  - rd_a/rd_b are purely combinational from rd_addr.
  - rd_addr >= DEPTH (non-power-of-2 DEPTH only) returns 0.
  - A read of the entry being written this cycle returns the old value (write takes effect at the clock edge).
- Arithmetic: wr_idx is AW bits. Wrap is explicit via compare to DEPTH-1, never by natural overflow.

Optional Feature:
- Macro: SAMPLE_ECHO_EN.
- Defined:
  - Adds output seg_echo (7 bits, active-low segments a..g, MSB=a).
  - Registered decode of the synchronized data_sw, 0-9 → team standard digit codes, 10-15 → 7'b1111111 (blank).
  - Reset value 7'b0000001 (digit 0).
  - Lets the operator confirm the value before commit.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package loader_pkg holds:
  - state enum (LOAD_A=0, LOAD_B=1, DONE=2);
  - DW/DEPTH defaults;
  - 7-segment digit-decode function, shared with the display path.
- Sub-module btn_debounce (synchronizer + counter + rising-edge pulse, param DEBOUNCE_CYC), instantiated twice (load, clear).

Test Plan (DEBOUNCE_CYC=4, DEPTH=8):
- Reset then idle: phase=0, wr_idx=0, load_done=0, rd_a=rd_b=0 for every rd_addr.
- Clean load: commit values 1..8 then 8..1 → phase 0→1 after the 8th commit, 1→2 after the 16th. start high exactly 1 cycle, load_done=1. rd_a[3]=4, rd_b[3]=5.
- Bounce: load_btn toggles every 2 cycles for 20 cycles, then holds high → exactly one write. Holding high 100 cycles → no further writes.
- DONE lock and clear: in DONE, press load with data_sw=9 → no buffer change. Press clear → phase=0, wr_idx=0, rd_a[0] still 1. Next commit of 9 → rd_a[0]=9.
- Collision: clr and commit pulses forced in the same cycle at wr_idx=5 in LOAD_B → phase=0, wr_idx=0, mem_b[5] unchanged.
- Reset mid-load at wr_idx=3 in LOAD_A → all entries 0, phase=0. With SAMPLE_ECHO_EN, data_sw=7 → seg_echo=7'b0001111; data_sw=12 → 7'b1111111.

Source files
------------

// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared loader states, default sizes and 7-segment digit decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        DONE   = 2'd2
    } load_state_t;

    localparam int c_DW_DEFAULT    = 4;
    localparam int c_DEPTH_DEFAULT = 8;

    // Active-low segments a..g, a in the MSB; non-decimal values blank the digit
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_loader_if.sv
// ============================================================================
// Module : sample_loader_if
// Brief  : Correlator-facing read port and completion signalling of the loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sample_loader_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          start;
    logic          load_done;

    modport master (
        output rd_addr,
        input  rd_a,
        input  rd_b,
        input  start,
        input  load_done
    );

    modport slave (
        input  rd_addr,
        output rd_a,
        output rd_b,
        output start,
        output load_done
    );
endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : 2-flop synchronizer, stability-count debouncer and rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  btn,
    output logic rise
);
    localparam int             C_CW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(DEBOUNCE_CYC - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_rise;
    logic [C_CW-1:0] r_cnt;

    // The level only flips after DEBOUNCE_CYC back-to-back mismatching cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == C_CNT_MAX) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/sample_loader.sv
// ============================================================================
// Module : sample_loader
// Brief  : Button-driven loader filling sample buffers A then B for the correlator.
//          Optional SAMPLE_ECHO_EN adds a 7-segment echo of the switch value.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_loader
    import loader_pkg::*;
#(
    parameter int DW           = c_DW_DEFAULT,
    parameter int DEPTH        = c_DEPTH_DEFAULT,
    parameter int AW           = $clog2(DEPTH),
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  wire           clk,
    input  wire           reset,
    input  wire  [DW-1:0] data_sw,
    input  wire           load_btn,
    input  wire           clear_btn,
    sample_loader_if.slave rd_bus,
    output logic [AW-1:0] wr_idx,
    output logic [1:0]    phase
`ifdef SAMPLE_ECHO_EN
    ,
    output logic [6:0]    seg_echo
`endif
);
    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    load_state_t   r_state;
    logic [AW-1:0] r_wr_idx;
    logic          r_start;
    logic          r_done;
    logic [DW-1:0] r_mem_a [DEPTH];
    logic [DW-1:0] r_mem_b [DEPTH];
    logic [DW-1:0] r_sw_s1;
    logic [DW-1:0] r_sw_s2;
    logic          w_commit;
    logic          w_clr;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_load_db (
        .clk   (clk),
        .reset (reset),
        .btn   (load_btn),
        .rise  (w_commit)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear_db (
        .clk   (clk),
        .reset (reset),
        .btn   (clear_btn),
        .rise  (w_clr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= data_sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // Clear takes priority over a commit landing in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= LOAD_A;
            r_wr_idx <= '0;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
        end else begin
            r_start <= 1'b0;
            if (w_clr) begin
                r_state  <= LOAD_A;
                r_wr_idx <= '0;
                r_done   <= 1'b0;
            end else if (w_commit) begin
                case (r_state)
                    LOAD_A: begin
                        r_mem_a[r_wr_idx] <= r_sw_s2;
                        if (r_wr_idx == C_LAST) begin
                            r_wr_idx <= '0;
                            r_state  <= LOAD_B;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                    LOAD_B: begin
                        r_mem_b[r_wr_idx] <= r_sw_s2;
                        if (r_wr_idx == C_LAST) begin
                            r_wr_idx <= '0;
                            r_state  <= DONE;
                            r_start  <= 1'b1;
                            r_done   <= 1'b1;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    generate
        if ((2 ** AW) == DEPTH) begin : g_rd_full
            assign rd_bus.rd_a = r_mem_a[rd_bus.rd_addr];
            assign rd_bus.rd_b = r_mem_b[rd_bus.rd_addr];
        end else begin : g_rd_guard
            logic w_in_range;
            assign w_in_range  = ({1'b0, rd_bus.rd_addr} < (AW + 1)'(DEPTH));
            assign rd_bus.rd_a = w_in_range ? r_mem_a[rd_bus.rd_addr] : '0;
            assign rd_bus.rd_b = w_in_range ? r_mem_b[rd_bus.rd_addr] : '0;
        end
    endgenerate

    assign rd_bus.start     = r_start;
    assign rd_bus.load_done = r_done;
    assign wr_idx           = r_wr_idx;
    assign phase            = r_state;

`ifdef SAMPLE_ECHO_EN
    logic [6:0] r_seg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg <= 7'b0000001;
        end else begin
            r_seg <= seg7_decode(4'(r_sw_s2));
        end
    end

    assign seg_echo = r_seg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_loader.sv
// ============================================================================
// Module : tb_sample_loader
// Brief  : Directed scoreboard bench for sample_loader (DEPTH=8, DEBOUNCE_CYC=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sample_loader;

    localparam int DW  = 4;
    localparam int DEP = 8;
    localparam int AW  = 3;

    typedef struct {
        bit         is_b;
        int         idx;
        logic [3:0] val;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_sw = '0;
    logic          load_btn = 1'b0;
    logic          clear_btn = 1'b0;
    logic [AW-1:0] wr_idx;
    logic [1:0]    phase;
`ifdef SAMPLE_ECHO_EN
    logic [6:0]    seg_echo;
`endif

    int         checks = 0;
    int         errors = 0;
    int         start_cnt = 0;
    rec_t       sb_q[$];
    logic [3:0] m_a [DEP];
    logic [3:0] m_b [DEP];
    int         m_phase = 0;
    int         m_idx = 0;

    sample_loader_if #(.DW(DW), .AW(AW)) bus ();

    sample_loader #(.DW(DW), .DEPTH(DEP), .DEBOUNCE_CYC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_sw   (data_sw),
        .load_btn  (load_btn),
        .clear_btn (clear_btn),
        .rd_bus    (bus.slave),
        .wr_idx    (wr_idx),
        .phase     (phase)
`ifdef SAMPLE_ECHO_EN
        ,
        .seg_echo  (seg_echo)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.start === 1'b1) start_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear_mem();
        for (int i = 0; i < DEP; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
    endtask

    // Expected effect of one accepted commit, recorded before the press
    task automatic sb_push(input logic [3:0] v);
        rec_t r;
        if (m_phase != 2) begin
            r.is_b = (m_phase == 1);
            r.idx  = m_idx;
            r.val  = v;
            sb_q.push_back(r);
            if (m_phase == 0) m_a[m_idx] = v;
            else              m_b[m_idx] = v;
            if (m_idx == DEP - 1) begin
                m_idx   = 0;
                m_phase = m_phase + 1;
            end else begin
                m_idx = m_idx + 1;
            end
        end
    endtask

    task automatic sb_check(input string tag);
        rec_t r;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            bus.rd_addr = AW'(r.idx);
            #1;
            if (r.is_b) check({tag, "_rd_b"}, 32'(bus.rd_b), 32'(r.val));
            else        check({tag, "_rd_a"}, 32'(bus.rd_a), 32'(r.val));
        end
        check({tag, "_wr_idx"}, 32'(wr_idx), 32'(m_idx));
        check({tag, "_phase"}, 32'(phase), 32'(m_phase));
    endtask

    task automatic check_all_mem(input string tag);
        for (int i = 0; i < DEP; i++) begin
            bus.rd_addr = AW'(i);
            #1;
            check({tag, "_a"}, 32'(bus.rd_a), 32'(m_a[i]));
            check({tag, "_b"}, 32'(bus.rd_b), 32'(m_b[i]));
        end
    endtask

    task automatic press_load(input logic [3:0] v, input string tag);
        data_sw = v;
        cycles(6);
        sb_push(v);
        load_btn = 1'b1;
        cycles(12);
        load_btn = 1'b0;
        cycles(12);
        sb_check(tag);
    endtask

    task automatic press_clear();
        clear_btn = 1'b1;
        cycles(12);
        clear_btn = 1'b0;
        cycles(12);
        m_phase = 0;
        m_idx   = 0;
    endtask

    initial begin
        bus.rd_addr = '0;
        model_clear_mem();

        // Reset and idle
        cycles(3);
        reset = 1'b1;
        cycles(5);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_wr_idx", 32'(wr_idx), 32'd0);
        check("rst_load_done", 32'(bus.load_done), 32'd0);
        check("rst_start", 32'(bus.start), 32'd0);
        check_all_mem("rst_mem");

        // Clean load: 1..8 into A, 8..1 into B
        for (int v = 1; v <= 8; v++) press_load(4'(v), "load_a");
        for (int v = 8; v >= 1; v--) press_load(4'(9 - (9 - v)), "load_b");
        check("done_phase", 32'(phase), 32'd2);
        check("done_flag", 32'(bus.load_done), 32'd1);
        check("start_pulses", 32'(start_cnt), 32'd1);
        check("start_low", 32'(bus.start), 32'd0);
        bus.rd_addr = 3'd3;
        #1;
        check("rd_a3", 32'(bus.rd_a), 32'd4);
        check("rd_b3", 32'(bus.rd_b), 32'd5);

        // DONE ignores commits
        press_load(4'd9, "done_lock");
        check("done_lock_flag", 32'(bus.load_done), 32'd1);
        check_all_mem("done_lock_mem");

        // Clear restarts at A[0] but keeps contents
        press_clear();
        check("clr_phase", 32'(phase), 32'd0);
        check("clr_wr_idx", 32'(wr_idx), 32'd0);
        check("clr_load_done", 32'(bus.load_done), 32'd0);
        bus.rd_addr = 3'd0;
        #1;
        check("clr_keep_a0", 32'(bus.rd_a), 32'd1);
        press_load(4'd9, "reload_a0");
        check("start_no_repeat", 32'(start_cnt), 32'd1);

        // Bouncing press then long hold: exactly one write
        data_sw = 4'd6;
        cycles(6);
        sb_push(4'd6);
        for (int i = 0; i < 10; i++) begin
            load_btn = ~load_btn;
            cycles(2);
        end
        load_btn = 1'b1;
        cycles(100);
        check("bounce_hold_idx", 32'(wr_idx), 32'(m_idx));
        load_btn = 1'b0;
        cycles(12);
        sb_check("bounce");
        check_all_mem("bounce_mem");

        // Reach LOAD_B index 5, then clear and commit together
        for (int i = 2; i < DEP; i++) press_load(4'(i + 3), "fill_a");
        for (int i = 0; i < 5; i++) press_load(4'(12 - i), "fill_b");
        check("pre_coll_phase", 32'(phase), 32'd1);
        check("pre_coll_idx", 32'(wr_idx), 32'd5);
        data_sw = 4'd15;
        cycles(6);
        load_btn  = 1'b1;
        clear_btn = 1'b1;
        cycles(12);
        load_btn  = 1'b0;
        clear_btn = 1'b0;
        cycles(12);
        m_phase = 0;
        m_idx   = 0;
        check("coll_phase", 32'(phase), 32'd0);
        check("coll_idx", 32'(wr_idx), 32'd0);
        bus.rd_addr = 3'd5;
        #1;
        check("coll_b5", 32'(bus.rd_b), 32'(m_b[5]));
        check_all_mem("coll_mem");

        // Reset in the middle of a load
        for (int i = 0; i < 3; i++) press_load(4'(10 + i), "pre_rst");
        check("pre_rst_idx", 32'(wr_idx), 32'd3);
        reset = 1'b0;
        cycles(2);
        model_clear_mem();
        m_phase = 0;
        m_idx   = 0;
        check("mid_rst_phase", 32'(phase), 32'd0);
        check("mid_rst_idx", 32'(wr_idx), 32'd0);
        check_all_mem("mid_rst_mem");
        reset = 1'b1;
        cycles(2);

`ifdef SAMPLE_ECHO_EN
        check("echo_rst", 32'(seg_echo), 32'(7'b0000001));
        data_sw = 4'd7;
        cycles(5);
        check("echo_7", 32'(seg_echo), 32'(7'b0001111));
        data_sw = 4'd12;
        cycles(5);
        check("echo_12", 32'(seg_echo), 32'(7'b1111111));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
